text_console_writer: RTL and testbench

Character-stream front end for the text-mode VGA path: accepts ASCII bytes over a valid/ready handshake and writes them into the 4096×8 screen memory that the VGA scan-out reads. It tracks a cursor and interprets a small set of control codes: newline, carriage return, backspace and form-feed. It scrolls the screen up by one row when the cursor runs off the bottom. It is the writer for the screen memory; the VGA block is the reader.

---
 rtl/text_console_writer.sv | 211 +++++++++++++++++++++
 tb/tb_text_console_writer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_writer.sv
// text_console_writer
//   Character-stream front end for the text-mode VGA path. Accepts ASCII
//   bytes over a valid/ready handshake and writes them into the COLS*ROWS
//   screen memory that the VGA scan-out reads. Tracks a cursor, interprets
//   BS (0x08), LF (0x0A), FF (0x0C) and CR (0x0D), and scrolls the screen up
//   one row when the cursor runs off the bottom.
//
//   Ports
//     clk, reset           system clock, synchronous active-high reset
//     char_data/valid      incoming byte, qualified by char_valid
//     char_ready           byte accepted on char_valid & char_ready
//     mem_addr/wdata/we    screen memory write port (row*COLS+col)
//     mem_rdata            combinational read data for mem_addr (mem_we=0)
//     cursor_col/row       current cursor position
//     busy                 FSM not idle (always !char_ready)
//
//   All memory-side outputs are registered and describe the operation of
//   the state the FSM is in during that cycle: whenever the FSM moves into a
//   state, the same edge loads the outputs that state must present.
module text_console_writer #(
  parameter int          COLS  = 80,
  parameter int          ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char_data,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  typedef enum logic [2:0] {
    CLEAR, IDLE, WRITE, BS_WRITE, SCROLL_RD, SCROLL_WR, SCROLL_CLR
  } state_t;

  localparam logic [11:0] COLS_A     = 12'(COLS);
  localparam logic [11:0] LAST_A     = 12'(COLS*ROWS-1);
  localparam logic [11:0] ROW_LAST_A = 12'((ROWS-1)*COLS);
  // Destination of the final copy in the scroll move (source = LAST_A).
  localparam logic [11:0] WR_LAST_A  = 12'((ROWS-1)*COLS-1);
  localparam logic [6:0]  COL_MAX    = 7'(COLS-1);
  localparam logic [4:0]  ROW_MAX    = 5'(ROWS-1);

  localparam logic [7:0] C_BS = 8'h08;
  localparam logic [7:0] C_LF = 8'h0A;
  localparam logic [7:0] C_FF = 8'h0C;
  localparam logic [7:0] C_CR = 8'h0D;

  state_t      state;
  logic [11:0] cur_addr;
  logic        accept;

  assign cur_addr = 12'(cursor_row) * COLS_A + 12'(cursor_col);
  assign accept   = char_valid & char_ready;
  assign busy     = ~char_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      // mem_we=0 here marks "clear not started yet"; CLEAR then begins at 0.
      state      <= CLEAR;
      cursor_col <= '0;
      cursor_row <= '0;
      char_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= BLANK;
    end else begin
      case (state)
        // mem_addr doubles as the sweep index for the clear.
        CLEAR: begin
          mem_wdata <= BLANK;
          if (!mem_we) begin
            mem_we   <= 1'b1;
            mem_addr <= '0;
          end else if (mem_addr == LAST_A) begin
            mem_we     <= 1'b0;
            char_ready <= 1'b1;
            state      <= IDLE;
          end else begin
            mem_addr <= mem_addr + 12'd1;
          end
        end

        IDLE: begin
          if (accept) begin
            case (char_data)
              C_CR: cursor_col <= '0;

              // LF without scroll keeps ready high: one byte per cycle.
              C_LF: begin
                cursor_col <= '0;
                if (cursor_row == ROW_MAX) begin
                  mem_addr   <= COLS_A;
                  mem_we     <= 1'b0;
                  char_ready <= 1'b0;
                  state      <= SCROLL_RD;
                end else begin
                  cursor_row <= cursor_row + 5'd1;
                end
              end

              // No wrap to the previous row at column 0.
              C_BS: begin
                if (cursor_col != '0) begin
                  cursor_col <= cursor_col - 7'd1;
                  mem_addr   <= cur_addr - 12'd1;
                  mem_wdata  <= BLANK;
                  mem_we     <= 1'b1;
                  char_ready <= 1'b0;
                  state      <= BS_WRITE;
                end
              end

              // Form feed starts writing immediately at address 0.
              C_FF: begin
                cursor_col <= '0;
                cursor_row <= '0;
                mem_addr   <= '0;
                mem_wdata  <= BLANK;
                mem_we     <= 1'b1;
                char_ready <= 1'b0;
                state      <= CLEAR;
              end

              default: begin
                mem_addr   <= cur_addr;
                mem_wdata  <= char_data;
                mem_we     <= 1'b1;
                char_ready <= 1'b0;
                state      <= WRITE;
              end
            endcase
          end
        end

        // Cursor advances as the write retires; bottom-right goes to scroll.
        WRITE: begin
          mem_we <= 1'b0;
          if (cursor_col == COL_MAX) begin
            cursor_col <= '0;
            if (cursor_row == ROW_MAX) begin
              mem_addr <= COLS_A;
              state    <= SCROLL_RD;
            end else begin
              cursor_row <= cursor_row + 5'd1;
              char_ready <= 1'b1;
              state      <= IDLE;
            end
          end else begin
            cursor_col <= cursor_col + 7'd1;
            char_ready <= 1'b1;
            state      <= IDLE;
          end
        end

        BS_WRITE: begin
          mem_we     <= 1'b0;
          char_ready <= 1'b1;
          state      <= IDLE;
        end

        // mem_addr = source i; rdata is combinational, capture it into wdata.
        SCROLL_RD: begin
          mem_wdata <= mem_rdata;
          mem_addr  <= mem_addr - COLS_A;
          mem_we    <= 1'b1;
          state     <= SCROLL_WR;
        end

        // mem_addr = i-COLS; next source is i+1 = mem_addr+COLS+1.
        SCROLL_WR: begin
          if (mem_addr == WR_LAST_A) begin
            mem_addr  <= ROW_LAST_A;
            mem_wdata <= BLANK;
            mem_we    <= 1'b1;
            state     <= SCROLL_CLR;
          end else begin
            mem_addr <= mem_addr + COLS_A + 12'd1;
            mem_we   <= 1'b0;
            state    <= SCROLL_RD;
          end
        end

        SCROLL_CLR: begin
          if (mem_addr == LAST_A) begin
            mem_we     <= 1'b0;
            char_ready <= 1'b1;
            state      <= IDLE;
          end else begin
            mem_addr <= mem_addr + 12'd1;
          end
        end

        default: begin
          state      <= CLEAR;
          mem_we     <= 1'b0;
          mem_addr   <= '0;
          char_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: a behavioural screen memory, a reference
// cursor/memory model that pushes expected writes into a queue as bytes are
// driven, and a monitor that pops and compares every DUT write in order.
module tb_text_console_writer;
  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int NCELL = COLS*ROWS;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  char_data = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready, mem_we, busy;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;

  logic [7:0]  mem     [0:4095];
  logic [7:0]  ref_mem [0:4095];
  logic [19:0] exp_q [$];
  int total = 0, bad = 0;
  int mrow = 0, mcol = 0;

  always #5 clk = ~clk;

  text_console_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(8'h20)) dut (
    .clk(clk), .reset(reset),
    .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );

  assign mem_rdata = mem_we ? 8'h00 : mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every write the DUT makes must be the next expected one.
  always @(negedge clk) begin
    if (mem_we && !reset) begin
      if (exp_q.size() == 0) chk("wr_extra", int'({mem_addr, mem_wdata}), -1);
      else chk("wr", int'({mem_addr, mem_wdata}), int'(exp_q.pop_front()));
    end
  end

  // ---------------- reference model ----------------
  function automatic void push_wr(input int a, input logic [7:0] d);
    exp_q.push_back({12'(a), d});
    ref_mem[a] = d;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < NCELL; i++) push_wr(i, 8'h20);
  endfunction

  function automatic void m_scroll();
    for (int i = COLS; i < NCELL; i++) push_wr(i-COLS, ref_mem[i]);
    for (int i = NCELL-COLS; i < NCELL; i++) push_wr(i, 8'h20);
  endfunction

  function automatic void m_apply(input logic [7:0] b);
    case (b)
      8'h0D: mcol = 0;
      8'h0A: begin
        mcol = 0;
        if (mrow == ROWS-1) m_scroll(); else mrow++;
      end
      8'h08: if (mcol > 0) begin mcol--; push_wr(mrow*COLS+mcol, 8'h20); end
      8'h0C: begin m_clear(); mrow = 0; mcol = 0; end
      default: begin
        push_wr(mrow*COLS+mcol, b);
        mcol++;
        if (mcol == COLS) begin
          mcol = 0;
          if (mrow == ROWS-1) m_scroll(); else mrow++;
        end
      end
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  // Returns at a negedge with char_ready high; cyc = busy negedges seen.
  task automatic wait_ready(input int bound, output int cyc);
    cyc = 0;
    @(negedge clk);
    while (!char_ready && cyc < bound) begin
      cyc++;
      @(negedge clk);
    end
    if (!char_ready) chk("timeout", 0, 1);
  endtask

  // Drives one byte for exactly one accepting edge; returns 1ns after it.
  task automatic send(input logic [7:0] b);
    int c;
    wait_ready(10000, c);
    char_data  = b;
    char_valid = 1'b1;
    m_apply(b);
    @(posedge clk); #1;
    char_valid = 1'b0;
  endtask

  task automatic settle(input string tag, input int r, input int c);
    int n;
    wait_ready(10000, n);
    chk({tag, "_q"},   exp_q.size(), 0);
    chk({tag, "_row"}, int'(cursor_row), r);
    chk({tag, "_col"}, int'(cursor_col), c);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bit got;
    for (int i = 0; i < 4096; i++) begin mem[i] = 8'hFF; ref_mem[i] = 8'hFF; end

    // reset state
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", char_ready, 0);
    chk("rst_busy",  busy, 1);
    chk("rst_we",    mem_we, 0);
    chk("rst_addr",  mem_addr, 0);
    chk("rst_wdata", mem_wdata, 8'h20);
    chk("rst_row",   cursor_row, 0);
    chk("rst_col",   cursor_col, 0);
    m_clear();
    settle("clr", 0, 0);

    // printable write timing: we in N+1, ready and cursor in N+2
    send(8'h41);
    @(negedge clk);
    chk("a_n1_ready", char_ready, 0);
    chk("a_n1_we",    mem_we, 1);
    @(negedge clk);
    chk("a_n2_ready", char_ready, 1);
    chk("a_n2_col",   cursor_col, 1);
    send(8'h42);
    settle("ab", 0, 2);

    send(8'h0C);
    settle("ff", 0, 0);

    // row wrap, CR, write at start of row 1
    for (int i = 0; i < COLS; i++) send(8'h78);
    settle("wrap", 1, 0);
    send(8'h0D);
    settle("cr", 1, 0);
    send(8'h79);
    settle("y", 1, 1);
    send(8'h0D);
    @(negedge clk);
    chk("cr_n1_col",   cursor_col, 0);
    chk("cr_n1_ready", char_ready, 1);
    send(8'h0A);
    @(negedge clk);
    chk("nl_n1_row",   cursor_row, 2);
    chk("nl_n1_ready", char_ready, 1);
    send(8'h0A);
    settle("nl", 3, 0);

    // backspace at col 0 is a no-op; at (3,5) blanks 244
    send(8'h08);
    settle("bs0", 3, 0);
    for (int i = 0; i < 5; i++) send(8'h71);
    settle("q5", 3, 5);
    send(8'h08);
    settle("bs", 3, 4);
    chk("bs_mem", mem[244], 8'h20);

    // scroll: cursor to (29,10), row 1 = 'R', last row = 'L'
    for (int i = 0; i < 26; i++) send(8'h0A);
    settle("pos", 29, 0);
    for (int i = 0; i < 10; i++) send(8'h4C);
    settle("pos2", 29, 10);
    for (int i = COLS; i < 2*COLS; i++) begin mem[i] = 8'h52; ref_mem[i] = 8'h52; end
    for (int i = NCELL-COLS+10; i < NCELL; i++) begin mem[i] = 8'h4C; ref_mem[i] = 8'h4C; end
    send(8'h0A);
    @(negedge clk);
    chk("scr_busy", busy, 1);
    chk("scr_we",   mem_we, 0);
    chk("scr_addr", mem_addr, COLS);
    wait_ready(6000, c);
    chk("scr_cycles", c + 1, 4720);
    chk("scr_q",   exp_q.size(), 0);
    chk("scr_row", cursor_row, 29);
    chk("scr_col", cursor_col, 0);
    for (int i = 0; i < COLS; i++) chk("scr_top", mem[i], 8'h52);
    for (int i = NCELL-2*COLS; i < NCELL-COLS; i++) chk("scr_r28", mem[i], 8'h4C);
    for (int i = NCELL-COLS; i < NCELL; i++) chk("scr_r29", mem[i], 8'h20);

    // write into bottom-right cell, then scroll directly
    for (int i = 0; i < COLS-1; i++) send(8'h7A);
    send(8'h77);
    settle("brwrap", 29, 0);
    chk("brwrap_mem", mem[NCELL-COLS-1], 8'h77);

    // reset mid-scroll, then FF held through the restarted clear
    send(8'h0A);
    repeat (100) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    mrow = 0; mcol = 0;
    m_clear();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rs_we",    mem_we, 0);
    chk("rs_ready", char_ready, 0);
    char_data  = 8'h0C;
    char_valid = 1'b1;
    m_apply(8'h0C);
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      if (char_ready) got = 1'b1;
      else @(negedge clk);
    end
    chk("rs_ready_seen", got, 1);
    chk("rs_first_q", exp_q.size(), NCELL);
    chk("rs_row", cursor_row, 0);
    chk("rs_col", cursor_col, 0);
    @(posedge clk); #1 char_valid = 1'b0;
    settle("ff_hold", 0, 0);
    repeat (5) @(negedge clk);
    chk("ff_hold_idle_q", exp_q.size(), 0);
    chk("ff_hold_ready", char_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
